// File: rtl/fifo_collect_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_collect_pkg
// Purpose : Shared types and helpers for the fifo_collect serial-to-parallel
//           collector (state encoding, counter width helper).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fifo_collect_pkg;

  // FILL: assembling a vector; FULL: complete vector held for the consumer.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } collect_state_t;

  // Width needed to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : fifo_collect_pkg
`default_nettype wire

// File: rtl/fifo_collect.sv
`default_nettype none
// ============================================================================
// Module  : fifo_collect
// Purpose : Collects DEPTH signed BITS-wide words, one per valid/ready
//           handshake, into a parallel vector. The first accepted word lands
//           in q[0]. A full vector can be handed off in the same cycle as the
//           first word of the next vector is accepted.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           flush           - close a partial vector (FIFO_COLLECT_FLUSH_EN only)
//           in_valid/in_ready/in_data - input word handshake
//           q               - assembled vector, q[0] oldest
//           out_valid/out_ready       - output vector handshake
//           count           - words held in the current vector
// Config  : define FIFO_COLLECT_FLUSH_EN to add the flush port and logic.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_collect
  import fifo_collect_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
`ifdef FIFO_COLLECT_FLUSH_EN
  input  logic                                flush,
`endif
  input  logic                                in_valid,
  input  logic signed [BITS-1:0]              in_data,
  output logic                                in_ready,
  output logic signed [BITS-1:0]              q [DEPTH],
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [cnt_width(DEPTH)-1:0]         count
);

  localparam int CW = cnt_width(DEPTH);

  collect_state_t r_state;
  collect_state_t w_state_nxt;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic [CW-1:0]  w_wr_idx;
  logic           w_wr;
  logic           w_clear;
  logic           w_accept;
  logic           w_handoff;
  logic           w_close;

  // In FULL the upstream may only push when the consumer is draining this
  // cycle, which lets the next vector's first word slip in with no bubble.
  assign in_ready  = rst ? 1'b0 : ((r_state == FILL) ? 1'b1 : out_ready);
  assign out_valid = (r_state == FULL);
  assign count     = r_count;

  assign w_accept  = in_valid && in_ready;
  assign w_handoff = out_valid && out_ready;

`ifdef FIFO_COLLECT_FLUSH_EN
  // A flush closes the vector only if it holds (or is about to hold) a word.
  assign w_close = flush && ((r_count != '0) || w_accept);
`else
  assign w_close = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_wr        = 1'b0;
    w_wr_idx    = r_count;
    w_clear     = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_wr        = 1'b1;
          w_count_nxt = r_count + CW'(1);
          if (r_count == CW'(DEPTH - 1)) begin
            w_state_nxt = FULL;
          end
        end
        if (w_close) begin
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (w_handoff) begin
          w_state_nxt = FILL;
          w_clear     = 1'b1;
          if (w_accept) begin
            w_wr        = 1'b1;
            w_wr_idx    = '0;
            w_count_nxt = CW'(1);
          end else begin
            w_count_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      // Clearing on handoff keeps unwritten entries at zero, never stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr && (w_wr_idx == CW'(i))) begin
          q[i] <= in_data;
        end else if (w_clear) begin
          q[i] <= '0;
        end
      end
    end
  end

endmodule : fifo_collect
`default_nettype wire

// File: tb/tb_fifo_collect.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_collect
// Purpose : Self-checking bench for fifo_collect (DEPTH=4, BITS=8). Expected
//           vector entries are queued as words are driven and popped when a
//           handoff is observed.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_collect;

  localparam int DEPTH = 4;
  localparam int BITS  = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic signed [BITS-1:0] in_data;
  logic                   in_ready;
  logic signed [BITS-1:0] q [DEPTH];
  logic                   out_valid;
  logic                   out_ready;
  logic [2:0]             count;

  logic signed [BITS-1:0] sb [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_collect #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef FIFO_COLLECT_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .q        (q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
  endtask

  task automatic test_reset();
    logic signed [BITS-1:0] e;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'sd55; out_ready = 1'b0; flush = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++;
    if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (q[i] !== e) begin n_err++; $display("FAIL reset_q%0d got=%0d exp=0", i, q[i]); end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic signed [BITS-1:0] words [4];
    logic signed [BITS-1:0] e;
    words[0] = -8'sd3; words[1] = 8'sd7; words[2] = 8'sd0; words[3] = 8'sd127;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = words[k]; sb.push_back(words[k]);
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL basic_fill k=%0d in_ready=%b out_valid=%b exp 1/0", k, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    n_vec++;
    if (count !== 3'd4) begin n_err++; $display("FAIL basic_count got=%0d exp=4", count); end
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      n_vec++;
      if (q[i] !== e) begin n_err++; $display("FAIL basic_q%0d got=%0d exp=%0d", i, q[i], e); end
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || count !== 3'd0 || q[0] !== 8'sd0 || q[3] !== 8'sd0) begin
      n_err++; $display("FAIL basic_after_handoff out_valid=%b count=%0d q0=%0d q3=%0d exp 0/0/0/0",
                        out_valid, count, q[0], q[3]);
    end
  endtask

  task automatic test_backpressure();
    logic signed [BITS-1:0] snap [DEPTH];
    logic signed [BITS-1:0] e;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = BITS'(11 + k); sb.push_back(BITS'(11 + k));
      tick();
    end
    for (int i = 0; i < DEPTH; i++) snap[i] = sb[i];
    in_valid = 1'b1; in_data = 8'sd5;
    #1;
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_stall c=%0d in_ready=%b out_valid=%b exp 0/1", c, in_ready, out_valid);
      end
      for (int i = 0; i < DEPTH; i++) begin
        n_vec++;
        if (q[i] !== snap[i]) begin n_err++; $display("FAIL bp_hold c=%0d q%0d got=%0d exp=%0d", c, i, q[i], snap[i]); end
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_passthru in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      n_vec++;
      if (q[i] !== e) begin n_err++; $display("FAIL bp_vec_q%0d got=%0d exp=%0d", i, q[i], e); end
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (count !== 3'd1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_restart count=%0d out_valid=%b exp 1/0", count, out_valid);
    end
    n_vec++;
    if (q[0] !== 8'sd5) begin n_err++; $display("FAIL bp_q0 got=%0d exp=5", q[0]); end
    for (int i = 1; i < DEPTH; i++) begin
      n_vec++;
      if (q[i] !== 8'sd0) begin n_err++; $display("FAIL bp_cleared_q%0d got=%0d exp=0", i, q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [BITS-1:0] e;
    logic exp_ov;
    int seen;
    do_reset();
    out_ready = 1'b1;
    seen = 0;
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) begin
        in_valid = 1'b1; in_data = BITS'(j + 1); sb.push_back(BITS'(j + 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ov = (j > 0) && (j % 4 == 0);
      n_vec++;
      if (out_valid !== exp_ov || in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_flow j=%0d out_valid=%b in_ready=%b exp %b/1", j, out_valid, in_ready, exp_ov);
      end
      if (out_valid === 1'b1 && sb.size() >= DEPTH) begin
        seen++;
        for (int i = 0; i < DEPTH; i++) begin
          e = sb.pop_front();
          n_vec++;
          if (q[i] !== e) begin n_err++; $display("FAIL b2b_vec%0d_q%0d got=%0d exp=%0d", seen, i, q[i], e); end
        end
      end
      tick();
    end
    n_vec++;
    if (seen != 3) begin n_err++; $display("FAIL b2b_vector_count got=%0d exp=3", seen); end
  endtask

  task automatic test_reset_mid();
    logic signed [BITS-1:0] e;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = BITS'(21 + k);
      tick();
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 8'sd99;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rmid_state count=%0d out_valid=%b exp 0/0", count, out_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (q[i] !== 8'sd0) begin n_err++; $display("FAIL rmid_q%0d got=%0d exp=0", i, q[i]); end
    end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = BITS'(31 + k); sb.push_back(BITS'(31 + k));
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || count !== 3'd4) begin
      n_err++; $display("FAIL rmid_full out_valid=%b count=%0d exp 1/4", out_valid, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      n_vec++;
      if (q[i] !== e) begin n_err++; $display("FAIL rmid_vec_q%0d got=%0d exp=%0d", i, q[i], e); end
    end
    tick();
  endtask

`ifdef FIFO_COLLECT_FLUSH_EN
  task automatic test_flush();
    logic signed [BITS-1:0] e;
    do_reset();
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL flush_empty out_valid=%b count=%0d exp 0/0", out_valid, count);
    end
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = BITS'(9 + k); sb.push_back(BITS'(9 + k));
      tick();
    end
    sb.push_back('0); sb.push_back('0);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || count !== 3'd2) begin
      n_err++; $display("FAIL flush_close out_valid=%b count=%0d exp 1/2", out_valid, count);
    end
    tick();
    flush = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || count !== 3'd2 || q[0] !== 8'sd9) begin
      n_err++; $display("FAIL flush_in_full out_valid=%b count=%0d q0=%0d exp 1/2/9", out_valid, count, q[0]);
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      n_vec++;
      if (q[i] !== e) begin n_err++; $display("FAIL flush_vec_q%0d got=%0d exp=%0d", i, q[i], e); end
    end
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'sd40; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || count !== 3'd1 || q[0] !== 8'sd40 || q[1] !== 8'sd0) begin
      n_err++; $display("FAIL flush_with_accept out_valid=%b count=%0d q0=%0d q1=%0d exp 1/1/40/0",
                        out_valid, count, q[0], q[1]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef FIFO_COLLECT_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_collect
`default_nettype wire

// File: doc/fifo_collect.md
# fifo_collect

Serial-to-parallel collector at the drain side of the systolic array: it accepts one signed BITS-wide result per handshake and assembles DEPTH of them into a parallel vector. The first accepted word lands in entry 0, so a collected vector can be loaded directly into the array's preloading input FIFOs with element order preserved. A valid/ready pair on each side provides backpressure. A full vector can be handed off in the same cycle that the first word of the next vector is accepted.

## Interface
- DEPTH, 8, entries per vector; legal range ≥2
- BITS, 8, signed width of each entry
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_data is valid this cycle
- in_data  in  signed [BITS-1:0]  result word to collect
- in_ready  out  1  collector accepts in_data this cycle
- q  out  signed [BITS-1:0] [DEPTH-1:0] (unpacked)  assembled vector; q[0] holds the oldest word
- out_valid  out  1  q holds a complete vector
- out_ready  in  1  consumer takes q this cycle
- count  out  $clog2(DEPTH+1)  words held in the current vector
- flush  in  1  close a partial vector; present only under FIFO_COLLECT_FLUSH_EN

## Operation
- Two states:
  - FILL: assembling a vector.
  - FULL: vector complete, held for the consumer.
- Accept is in_valid && in_ready. Handoff is out_valid && out_ready.
- FILL:
  - in_ready=1 and out_valid=0.
  - On accept, q[count] <= in_data and count increments.
  - When the accept brings count to DEPTH, the next state is FULL.
- FULL:
  - out_valid=1 and in_ready=out_ready (combinational pass-through).
  - q and count hold stable until handoff.
- On handoff:
  - Next state is FILL.
  - All q entries are cleared to 0.
  - If an accept occurs in the same cycle, q[0] <= in_data and count=1. Otherwise count=0.
- Entries not yet written in FILL read as 0. They are never stale data from the previous vector.
- in_data is stored unmodified; no arithmetic is performed on it. count never exceeds DEPTH.
- in_valid without in_ready is a stall. The upstream producer holds its word; nothing is dropped.
- Handshake rules:
  - out_valid never deasserts without a handoff.
  - q is guaranteed stable only while out_valid=1.

## Timing
- Reset (rst high at posedge):
  - State=FILL, count=0, all q entries 0, out_valid=0.
  - in_ready is forced 0 during any cycle in which rst is high.
- Reset asserted mid-vector or during FULL discards the partial or held vector. There is no handoff.
- out_valid rises in the cycle after the DEPTH-th accept. Latency from the last word to vector valid is 1 cycle.
- out_valid and q are registered outputs. in_ready and count are combinational from state/registers only, except the FULL-state in_ready=out_ready path.
- With in_valid=1 and out_ready=1 held, sustained throughput is 1 word/cycle with no bubble at the vector boundary.
- With out_ready=0 in FULL, in_ready=0 and the collector stalls indefinitely.

## Configuration
- FIFO_COLLECT_FLUSH_EN defined:
  - The flush port exists.
  - flush=1 in FILL with count>0 moves to FULL next cycle. Unwritten entries stay 0; count reports the partial fill.
  - flush together with an accept in the same cycle stores the word first, then closes the vector.
  - flush with count=0 and no accept is ignored.
  - flush in FULL is ignored.
- FIFO_COLLECT_FLUSH_EN undefined:
  - No flush port and no flush logic.
  - Vectors close only at count=DEPTH.

## Structure
- Package fifo_collect_pkg:
  - typedef enum logic {FILL, FULL} collect_state_t
  - localparam-style function cnt_width(depth) returning $clog2(depth+1)
- Single flat module; no sub-module is warranted. The write-indexed register array, the counter and the two-state FSM fit in one always_ff plus a small always_comb.

## Test plan
- DEPTH=4, BITS=8, out_ready=1. Accept -3, 7, 0, 127 on consecutive cycles:
  - out_valid=1 one cycle after 127.
  - q = {-3, 7, 0, 127} with q[0]=-3.
  - count=4.
- Backpressure: out_ready=0 after a full vector, in_valid held with 5:
  - in_ready=0.
  - q stays stable for 10 cycles.
  - Raise out_ready: handoff occurs, 5 is accepted the same cycle into q[0], count=1, q[1..3]=0.
- Back-to-back stream of 1..12 with in_valid and out_ready held 1:
  - Three vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}.
  - No idle cycle between them.
- Reset mid-vector: after 2 accepts, pulse rst for one cycle:
  - count=0, all q entries 0, out_valid=0.
  - in_ready=0 during the rst cycle.
  - Next 4 accepts form a clean vector.
- Flush (FIFO_COLLECT_FLUSH_EN): accept 9, 10, then flush:
  - FULL next cycle, q={9,10,0,0}, count=2.
  - Flush with count=0: no change.
  - Flush in FULL: ignored.
